quad_step_decoder: RTL and testbench



---
 rtl/quad_step_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_quad_step_decoder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : quad_step_decoder                                          |
// | Description : Quadrature (A/B) encoder front end. Synchronises and       |
// |               glitch-filters both phases, tracks the Gray-code position, |
// |               and emits mutually exclusive one-cycle increment and       |
// |               decrement strobes for a downstream up/down counter.        |
// |               Illegal two-bit transitions raise a sticky err flag.       |
// | Options     : QUAD_X4_EN defined   -> strobe on every legal Gray step.   |
// |               QUAD_X4_EN undefined -> strobe only on entry to state 00.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module quad_step_decoder #(
  parameter int SYNC_STAGES   = 2,  // synchroniser depth per phase, 2..4
  parameter int FILTER_CYCLES = 4   // cycles a new phase value must hold, 1..255
) (
  input  logic clk,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enable,
  input  logic err_clr,
  output logic increment,
  output logic decrement,
  output logic dir,
  output logic err
);

  // Counter value at which the next differing cycle completes the hold time.
  localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);

  // Synchroniser pipelines, plus a fill marker that tells us when the last
  // stage carries a genuinely sampled value rather than the reset value.
  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;

  // Glitch filters
  logic [7:0] cnt_a_q, cnt_a_d;
  logic [7:0] cnt_b_q, cnt_b_d;
  logic       f_a_q, f_a_d;
  logic       f_b_q, f_b_d;

  // Position tracking
  logic [1:0] prev_q, prev_d;
  logic       primed_q, primed_d;

  // Registered outputs
  logic increment_q, increment_d;
  logic decrement_q, decrement_d;
  logic dir_q, dir_d;
  logic err_q, err_d;

  // Combinational decode
  logic       s_a, s_b;
  logic [1:0] state;
  logic       settled;
  logic       fwd_step;
  logic       rev_step;
  logic       illegal_step;
  logic       inc_evt;
  logic       dec_evt;

  // Next Gray position in the forward direction: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Next Gray position in the reverse direction: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] rev_next(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  assign s_a   = sync_a_q[SYNC_STAGES-1];
  assign s_b   = sync_b_q[SYNC_STAGES-1];
  assign state = {f_a_q, f_b_q};

  // Shift both phases and the fill marker through the synchroniser chain.
  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b};
    fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Accept a new phase value only after it has differed for FILTER_CYCLES cycles.
  always_comb begin
    cnt_a_d = '0;
    f_a_d   = f_a_q;
    if (s_a != f_a_q) begin
      if (cnt_a_q == FILT_LAST) begin
        f_a_d = s_a;
      end else begin
        cnt_a_d = cnt_a_q + 8'd1;
      end
    end

    cnt_b_d = '0;
    f_b_d   = f_b_q;
    if (s_b != f_b_q) begin
      if (cnt_b_q == FILT_LAST) begin
        f_b_d = s_b;
      end else begin
        cnt_b_d = cnt_b_q + 8'd1;
      end
    end
  end

  // Classify the transition from the previous filtered position and form strobes.
  always_comb begin
    // Settled: the synchroniser has filled since reset and neither filter
    // has a pending change, so the filtered state reflects the encoder rest
    // position and can serve as the reference.
    settled = fill_q[SYNC_STAGES-1] && (s_a == f_a_q) && (s_b == f_b_q);

    fwd_step     = primed_q && (state == fwd_next(prev_q));
    rev_step     = primed_q && (state == rev_next(prev_q));
    illegal_step = primed_q && ((state ^ prev_q) == 2'b11);

`ifdef QUAD_X4_EN
    inc_evt = fwd_step;
    dec_evt = rev_step;
`else
    // x1: count only on arrival at 00 (from 01 forward, from 10 reverse).
    inc_evt = fwd_step && (state == 2'b00);
    dec_evt = rev_step && (state == 2'b00);
`endif

    primed_d = primed_q;
    prev_d   = prev_q;
    if (primed_q) begin
      prev_d = state;
    end else if (settled) begin
      primed_d = 1'b1;
      prev_d   = state;
    end

    // fwd_step and rev_step can never coincide, so the strobes are exclusive.
    increment_d = enable && inc_evt;
    decrement_d = enable && dec_evt;

    dir_d = dir_q;
    if (fwd_step) begin
      dir_d = 1'b1;
    end else if (rev_step) begin
      dir_d = 1'b0;
    end

    // A new illegal step takes precedence over a simultaneous clear.
    err_d = illegal_step || (err_q && !err_clr);
  end

  // All state registers, cleared asynchronously so in-flight strobes drop at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a_q    <= '0;
      sync_b_q    <= '0;
      fill_q      <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      f_a_q       <= 1'b0;
      f_b_q       <= 1'b0;
      prev_q      <= 2'b00;
      primed_q    <= 1'b0;
      increment_q <= 1'b0;
      decrement_q <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync_a_q    <= sync_a_d;
      sync_b_q    <= sync_b_d;
      fill_q      <= fill_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      f_a_q       <= f_a_d;
      f_b_q       <= f_b_d;
      prev_q      <= prev_d;
      primed_q    <= primed_d;
      increment_q <= increment_d;
      decrement_q <= decrement_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
    end
  end

  assign increment = increment_q;
  assign decrement = decrement_q;
  assign dir       = dir_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_quad_step_decoder                                       |
// | Description : Directed self-checking bench for quad_step_decoder at      |
// |               default parameters (SYNC_STAGES=2, FILTER_CYCLES=4).       |
// |               Expected strobe counts follow QUAD_X4_EN when defined.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_quad_step_decoder;

`ifdef QUAD_X4_EN
  localparam int X4 = 1;
`else
  localparam int X4 = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic enc_a;
  logic enc_b;
  logic enable;
  logic err_clr;
  logic increment;
  logic decrement;
  logic dir;
  logic err;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse statistics gathered on the falling edge
  int  inc_pulses = 0;
  int  dec_pulses = 0;
  int  wide_pulses = 0;
  int  both_high = 0;
  logic inc_prev = 1'b0;
  logic dec_prev = 1'b0;

  quad_step_decoder #(
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .enable   (enable),
    .err_clr  (err_clr),
    .increment(increment),
    .decrement(decrement),
    .dir      (dir),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Count strobe pulses and note any wide or overlapping strobes.
  always @(negedge clk) begin
    if (increment && !inc_prev) inc_pulses = inc_pulses + 1;
    if (decrement && !dec_prev) dec_pulses = dec_pulses + 1;
    if ((increment && inc_prev) || (decrement && dec_prev)) wide_pulses = wide_pulses + 1;
    if (increment && decrement) both_high = both_high + 1;
    inc_prev = increment;
    dec_prev = decrement;
  end

  task automatic clear_stats();
    inc_pulses  = 0;
    dec_pulses  = 0;
    wide_pulses = 0;
    both_high   = 0;
  endtask

  // Move the encoder to {a,b} and hold 20 cycles; strobes must be quiet after
  // edge 6, equal {exp_inc,exp_dec} after edge 7, and quiet again after edge 8.
  task automatic step(input logic a, input logic b, input int exp_inc, input int exp_dec,
                      input string name);
    logic [1:0] exp_s;
    exp_s = {exp_inc[0], exp_dec[0]};
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 6 || c == 8) begin
        n_checks++;
        if ({increment, decrement} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s quiet@edge%0d: {inc,dec}=%b expected 00", name, c, {increment, decrement});
        end
      end
      if (c == 7) begin
        n_checks++;
        if ({increment, decrement} !== exp_s) begin
          n_fail++;
          $display("FAIL %s strobe@edge7: {inc,dec}=%b expected %b", name, {increment, decrement}, exp_s);
        end
      end
    end
  endtask

  task automatic check_totals(input string name, input int e_inc, input int e_dec, input logic e_dir,
                              input logic e_err);
    n_checks++;
    if (inc_pulses != e_inc) begin
      n_fail++;
      $display("FAIL %s inc_count: got %0d expected %0d", name, inc_pulses, e_inc);
    end
    n_checks++;
    if (dec_pulses != e_dec) begin
      n_fail++;
      $display("FAIL %s dec_count: got %0d expected %0d", name, dec_pulses, e_dec);
    end
    n_checks++;
    if (wide_pulses != 0 || both_high != 0) begin
      n_fail++;
      $display("FAIL %s strobe_shape: wide=%0d overlap=%0d expected 0/0", name, wide_pulses, both_high);
    end
    n_checks++;
    if (dir !== e_dir) begin
      n_fail++;
      $display("FAIL %s dir: got %b expected %b", name, dir, e_dir);
    end
    n_checks++;
    if (err !== e_err) begin
      n_fail++;
      $display("FAIL %s err: got %b expected %b", name, err, e_err);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enc_a   = 1'b0;
    enc_b   = 1'b0;
    enable  = 1'b1;
    err_clr = 1'b0;
    #1;
    n_checks++;
    if ({increment, decrement, dir, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: {inc,dec,dir,err}=%b expected 0000", {increment, decrement, dir, err});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    clear_stats();
    n_checks++;
    if ({increment, decrement, dir, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: {inc,dec,dir,err}=%b expected 0000", {increment, decrement, dir, err});
    end
  endtask

  task automatic test_forward();
    clear_stats();
    step(1'b1, 1'b0, X4, 0, "fwd_10");
    step(1'b1, 1'b1, X4, 0, "fwd_11");
    step(1'b0, 1'b1, X4, 0, "fwd_01");
    step(1'b0, 1'b0, 1,  0, "fwd_00");
    check_totals("forward", 3 * X4 + 1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reverse();
    clear_stats();
    step(1'b0, 1'b1, 0, X4, "rev_01");
    step(1'b1, 1'b1, 0, X4, "rev_11");
    step(1'b1, 1'b0, 0, X4, "rev_10");
    step(1'b0, 1'b0, 0, 1,  "rev_00");
    check_totals("reverse", 0, 3 * X4 + 1, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    clear_stats();
    @(negedge clk);
    enc_a = 1'b1;
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    repeat (20) @(negedge clk);
    check_totals("glitch", 0, 0, 1'b0, 1'b0);
    // Filter must still accept a properly held step afterwards.
    clear_stats();
    step(1'b1, 1'b0, X4, 0, "post_glitch_10");
    step(1'b0, 1'b0, 0, 1,  "post_glitch_00");
    check_totals("post_glitch", X4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    clear_stats();
    @(negedge clk);
    enc_a = 1'b1;
    enc_b = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 6) begin
        n_checks++;
        if (err !== 1'b0) begin
          n_fail++;
          $display("FAIL illegal_err_early: err=%b expected 0", err);
        end
      end
      if (c == 7) begin
        n_checks++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL illegal_err_set: err=%b expected 1", err);
        end
      end
    end
    check_totals("illegal_00_11", 0, 0, 1'b0, 1'b1);

    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: err=%b expected 0", err);
    end
    @(negedge clk);
    err_clr = 1'b0;

    // Clear asserted in the same cycle the second illegal step is evaluated.
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 6) begin
        n_checks++;
        if (err !== 1'b0) begin
          n_fail++;
          $display("FAIL illegal2_err_early: err=%b expected 0", err);
        end
        err_clr = 1'b1;
      end
      if (c == 7) begin
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL set_beats_clr: err=%b expected 1", err);
        end
      end
    end
    check_totals("illegal_11_00", 0, 0, 1'b0, 1'b1);

    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_prime_nonzero();
    @(negedge clk);
    reset = 1'b1;
    enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (3) @(negedge clk);
    clear_stats();
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check_totals("prime_11", 0, 0, 1'b0, 1'b0);
    clear_stats();
    step(1'b0, 1'b1, X4, 0, "prime_11_01");
    step(1'b0, 1'b0, 1,  0, "prime_01_00");
    check_totals("prime_steps", X4 + 1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_enable_and_reset();
    clear_stats();
    @(negedge clk);
    enable = 1'b0;
    step(1'b0, 1'b1, 0, 0, "dis_00_01");
    n_checks++;
    if (dir !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_rev_dir: dir=%b expected 0", dir);
    end
    step(1'b0, 1'b0, 0, 0, "dis_01_00");
    step(1'b1, 1'b0, 0, 0, "dis_00_10");
    check_totals("disabled", 0, 0, 1'b1, 1'b0);

    clear_stats();
    @(negedge clk);
    enable = 1'b1;
    step(1'b1, 1'b1, X4, 0, "en_10_11");
    step(1'b0, 1'b1, X4, 0, "en_11_01");
    check_totals("enabled", 2 * X4, 0, 1'b1, 1'b0);

    // Catch the 01->00 increment strobe and reset while it is high.
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (increment !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_strobe: increment=%b expected 1", increment);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({increment, decrement, dir, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_drop: {inc,dec,dir,err}=%b expected 0000", {increment, decrement, dir, err});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_prime_nonzero();
    test_enable_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
